flash_sample_reader: RTL and testbench
======================================

# flash_sample_reader

Upstream audio-source stage. Fetches 32-bit words from the on-board flash over a read/waitrequest/readdatavalid interface, splits each word into two 16-bit audio samples, and offers them one at a time to the pass-to-audio stage on `getdata`. A sample is released when the downstream stage pulses `confirm_pass`. Keyboard codes on `key_control` set playback direction and restart.

## Interface
- `ADDR_W`, 23: flash word-address width.
- `FIRST_ADDR`, 23'h0: first word of the song.
- `LAST_ADDR`, 23'h7FFFF: last word of the song.

Ports:
- `clock50`  in  1: system clock, 50 MHz; sole clock.
- `rstn`  in  1: reset, asynchronous, active-low.
- `key_control`  in  8: keyboard ASCII code, held level.
- `confirm_pass`  in  1: one-cycle pulse from the downstream stage; current sample consumed.
- `flash_mem_read`  out  1: read request.
- `flash_mem_waitrequest`  in  1: flash stall; request held while high.
- `flash_mem_address`  out  ADDR_W: word address.
- `flash_mem_readdata`  in  32: read word.
- `flash_mem_readdatavalid`  in  1: `flash_mem_readdata` valid this cycle.
- `getdata`  out  16: current sample.
- `data_ready`  out  1: `getdata` holds an unconsumed sample.

## Operation
- Reset values:
  - `flash_mem_read` = 0, `data_ready` = 0, `getdata` = 0.
  - `flash_mem_address` = `FIRST_ADDR`.
  - Direction = forward, restart_pending = 0, state = IDLE.
- Key decoding (sampled every cycle):
  - 8'h46 'F' sets direction forward.
  - 8'h42 'B' sets direction backward.
  - 8'h52 'R' sets restart_pending.
  - Other codes are ignored.
- States:
  - IDLE: go to REQ next cycle.
  - REQ: `flash_mem_read` = 1 with `flash_mem_address` stable. The request is accepted in the first cycle with `flash_mem_waitrequest` = 0. `flash_mem_read` drops the following cycle, then go to WAIT.
  - WAIT: on `flash_mem_readdatavalid` = 1, capture the word and go to HALF0.
  - HALF0:
    - `getdata` = first half (forward: `readdata[15:0]`; backward: `readdata[31:16]`), `data_ready` = 1.
    - On `confirm_pass`, go to HALF1.
  - HALF1:
    - `getdata` = second half (the other 16 bits), `data_ready` = 1.
    - On `confirm_pass`, compute the next address and go to REQ.
- Next-address rule, evaluated on leaving HALF1:
  - If restart_pending: forward → `FIRST_ADDR`, backward → `LAST_ADDR`; clear restart_pending.
  - Else forward: address+1, except `LAST_ADDR` → `FIRST_ADDR`.
  - Else backward: address−1, except `FIRST_ADDR` → `LAST_ADDR`.
- A direction change takes effect at the next word boundary. The half order of the word already captured does not change.
- `confirm_pass` while `data_ready` = 0 is ignored.
- Address arithmetic is modulo the [`FIRST_ADDR`, `LAST_ADDR`] range and never leaves it.

## Timing
- `getdata` and `data_ready` are registered.
- `data_ready` rises the cycle after the `readdatavalid` cycle.
- In HALF1, `data_ready` drops the cycle after `confirm_pass` and stays low until the next word arrives.
- HALF0→HALF1: `getdata` updates the cycle after `confirm_pass`; `data_ready` stays high.
- Minimum word turnaround with no waitstates and readdatavalid one cycle after accept: 4 cycles from the HALF1 `confirm_pass` to `data_ready` high.
- Simultaneous 'R' and the HALF1 `confirm_pass`: the restart applies to this boundary.
- Reset asserted mid-read:
  - All state clears immediately.
  - A late `readdatavalid` after reset release while in IDLE/REQ is ignored.

## Configuration
- `FLASH_READER_BYTESWAP_EN` defined: each 16-bit sample is byte-swapped before driving `getdata` (`{s[7:0], s[15:8]}`).
- Undefined: samples pass unmodified.
- No other behaviour differs.

## Test plan
- Reset, flash returns 32'hAAAA5555 with no waitstates:
  - `flash_mem_address` = 0.
  - `getdata` = 16'h5555, then 16'hAAAA after one `confirm_pass`.
  - Read of address 1 is issued after the second pulse.
- `flash_mem_waitrequest` held high 5 cycles: `flash_mem_read` and `flash_mem_address` stay stable through all 5; exactly one request is accepted.
- Forward at `LAST_ADDR`: after two `confirm_pass` pulses, the next address is `FIRST_ADDR`.
- Backward at `FIRST_ADDR`:
  - The next address is `LAST_ADDR`.
  - Word 32'h12345678 yields 16'h1234 then 16'h5678.
- 'R' during HALF0 at address 100 forward: the next request is to `FIRST_ADDR`; with 'B' also pressed, the next request is to `LAST_ADDR`.
- `confirm_pass` pulsed while in WAIT: ignored. With `FLASH_READER_BYTESWAP_EN` defined, 32'h0000BEEF yields 16'hEFBE.

Source files
------------

// File: rtl/flash_sample_reader_if.sv
// Flash read bus: read/waitrequest request phase plus readdatavalid return.
// The reader drives the master side; the flash (or its model) sits on the slave side.
interface flash_sample_reader_if #(
   parameter int unsigned ADDR_W = 23
);
   logic              flash_mem_read;
   logic              flash_mem_waitrequest;
   logic [ADDR_W-1:0] flash_mem_address;
   logic [31:0]       flash_mem_readdata;
   logic              flash_mem_readdatavalid;

   modport master (
      output flash_mem_read,
      output flash_mem_address,
      input  flash_mem_waitrequest,
      input  flash_mem_readdata,
      input  flash_mem_readdatavalid
   );

   modport slave (
      input  flash_mem_read,
      input  flash_mem_address,
      output flash_mem_waitrequest,
      output flash_mem_readdata,
      output flash_mem_readdatavalid
   );
endinterface

// File: rtl/flash_sample_reader.sv
// Fetches 32-bit flash words and hands them out as two 16-bit samples per word.
// Define FLASH_READER_BYTESWAP_EN to byte-swap every sample on getdata.
module flash_sample_reader #(
   parameter int unsigned       ADDR_W     = 23,
   parameter logic [ADDR_W-1:0] FIRST_ADDR = '0,
   parameter logic [ADDR_W-1:0] LAST_ADDR  = 23'h7FFFF
) (
   input  logic                         clock50,
   input  logic                         rstn,
   input  logic [7:0]                   key_control,
   input  logic                         confirm_pass,
   flash_sample_reader_if.master        flash,
   output logic [15:0]                  getdata,
   output logic                         data_ready
);

   typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_HALF0, S_HALF1} state_t;

   localparam logic [7:0] KEY_F = 8'h46;
   localparam logic [7:0] KEY_B = 8'h42;
   localparam logic [7:0] KEY_R = 8'h52;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [31:0]       word_q, word_d;
   logic              wdir_q, wdir_d;     // half order of the captured word, 1 = backward
   logic              dir_q, dir_d;       // playback direction, 1 = backward
   logic              rst_pend_q, rst_pend_d;
   logic [15:0]       getdata_q, getdata_d;
   logic              ready_q, ready_d;
   logic              restart_now;

   function automatic logic [15:0] fmt(input logic [15:0] s);
`ifdef FLASH_READER_BYTESWAP_EN
      return {s[7:0], s[15:8]};
`else
      return s;
`endif
   endfunction

   always_ff @(posedge clock50 or negedge rstn) begin
      if (!rstn) begin
         state_q    <= S_IDLE;
         addr_q     <= FIRST_ADDR;
         word_q     <= '0;
         wdir_q     <= 1'b0;
         dir_q      <= 1'b0;
         rst_pend_q <= 1'b0;
         getdata_q  <= '0;
         ready_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         addr_q     <= addr_d;
         word_q     <= word_d;
         wdir_q     <= wdir_d;
         dir_q      <= dir_d;
         rst_pend_q <= rst_pend_d;
         getdata_q  <= getdata_d;
         ready_q    <= ready_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      addr_d     = addr_q;
      word_d     = word_q;
      wdir_d     = wdir_q;
      dir_d      = dir_q;
      rst_pend_d = rst_pend_q;
      getdata_d  = getdata_q;
      ready_d    = ready_q;

      case (key_control)
         KEY_F:   dir_d = 1'b0;
         KEY_B:   dir_d = 1'b1;
         default: ;
      endcase
      // An 'R' arriving in the same cycle as the boundary still counts for it.
      restart_now = rst_pend_q | (key_control == KEY_R);
      rst_pend_d  = restart_now;

      case (state_q)
         S_IDLE: state_d = S_REQ;
         S_REQ: begin
            if (!flash.flash_mem_waitrequest) state_d = S_WAIT;
         end
         S_WAIT: begin
            if (flash.flash_mem_readdatavalid) begin
               word_d    = flash.flash_mem_readdata;
               wdir_d    = dir_q;
               getdata_d = fmt(dir_q ? flash.flash_mem_readdata[31:16]
                                     : flash.flash_mem_readdata[15:0]);
               ready_d   = 1'b1;
               state_d   = S_HALF0;
            end
         end
         S_HALF0: begin
            if (confirm_pass) begin
               getdata_d = fmt(wdir_q ? word_q[15:0] : word_q[31:16]);
               state_d   = S_HALF1;
            end
         end
         S_HALF1: begin
            if (confirm_pass) begin
               ready_d    = 1'b0;
               state_d    = S_REQ;
               rst_pend_d = 1'b0;
               if (restart_now)
                  addr_d = dir_d ? LAST_ADDR : FIRST_ADDR;
               else if (!dir_d)
                  addr_d = (addr_q >= LAST_ADDR) ? FIRST_ADDR : addr_q + ADDR_W'(1);
               else
                  addr_d = (addr_q <= FIRST_ADDR) ? LAST_ADDR : addr_q - ADDR_W'(1);
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign flash.flash_mem_read    = (state_q == S_REQ);
   assign flash.flash_mem_address = addr_q;
   assign getdata                 = getdata_q;
   assign data_ready              = ready_q;

endmodule

// File: tb/tb_flash_sample_reader.sv
// Directed bench for flash_sample_reader with a small flash model that can
// insert waitstates and extra read latency.
module tb_flash_sample_reader;

   logic        clock50 = 1'b0;
   logic        rstn = 1'b0;
   logic [7:0]  key_control = 8'h00;
   logic        confirm_pass = 1'b0;
   logic [15:0] getdata;
   logic        data_ready;

   int nvec = 0;
   int nerr = 0;

   flash_sample_reader_if #(.ADDR_W(23)) fif ();

   flash_sample_reader dut (
      .clock50      (clock50),
      .rstn         (rstn),
      .key_control  (key_control),
      .confirm_pass (confirm_pass),
      .flash        (fif.master),
      .getdata      (getdata),
      .data_ready   (data_ready)
   );

   always #10 clock50 = ~clock50;

   // flash model: ws_req stall cycles per request, lat_req extra return latency
   logic [31:0] flash_word = 32'h0;
   int          ws_req = 0;
   int          lat_req = 0;
   int          ws_cnt = 0;
   int          accepts = 0;
   int          dly = 0;
   logic        pend = 1'b0;
   logic [31:0] pend_data = 32'h0;

   assign fif.flash_mem_waitrequest = fif.flash_mem_read && (ws_cnt < ws_req);

   initial begin
      fif.flash_mem_readdatavalid = 1'b0;
      fif.flash_mem_readdata      = 32'h0;
   end

   always @(posedge clock50) begin
      fif.flash_mem_readdatavalid <= 1'b0;
      if (pend) begin
         if (dly <= 1) begin
            fif.flash_mem_readdatavalid <= 1'b1;
            fif.flash_mem_readdata      <= pend_data;
            pend <= 1'b0;
         end else
            dly <= dly - 1;
      end
      if (fif.flash_mem_read) begin
         if (ws_cnt < ws_req)
            ws_cnt <= ws_cnt + 1;
         else begin
            accepts <= accepts + 1;
            ws_cnt  <= 0;
            if (lat_req == 0) begin
               fif.flash_mem_readdatavalid <= 1'b1;
               fif.flash_mem_readdata      <= flash_word;
            end else begin
               pend      <= 1'b1;
               dly       <= lat_req;
               pend_data <= flash_word;
            end
         end
      end
   end

   function automatic logic [15:0] exp16(input logic [15:0] s);
`ifdef FLASH_READER_BYTESWAP_EN
      return {s[7:0], s[15:8]};
`else
      return s;
`endif
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nvec++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic wait_ready(output int n);
      n = 0;
      while (data_ready !== 1'b1 && n < 50) begin
         @(negedge clock50);
         n++;
      end
      chk("ready_timeout", 32'(data_ready), 32'd1);
   endtask

   task automatic pulse();
      confirm_pass = 1'b1;
      @(negedge clock50);
      confirm_pass = 1'b0;
   endtask

   task automatic key(input logic [7:0] k);
      key_control = k;
      @(negedge clock50);
      key_control = 8'h00;
   endtask

   initial begin
      int n;
      int a0;

      // reset state
      flash_word = 32'hAAAA5555;
      @(negedge clock50);
      chk("rst_read",  32'(fif.flash_mem_read), 32'd0);
      chk("rst_ready", 32'(data_ready), 32'd0);
      chk("rst_data",  32'(getdata), 32'd0);
      chk("rst_addr",  32'(fif.flash_mem_address), 32'd0);
      rstn = 1'b1;

      // first word, forward halves
      wait_ready(n);
      chk("w0_addr",  32'(fif.flash_mem_address), 32'd0);
      chk("w0_half0", 32'(getdata), 32'(exp16(16'h5555)));
      pulse();
      chk("w0_half1", 32'(getdata), 32'(exp16(16'hAAAA)));
      chk("w0_ready_h1", 32'(data_ready), 32'd1);
      pulse();
      chk("w1_read",  32'(fif.flash_mem_read), 32'd1);
      chk("w1_addr",  32'(fif.flash_mem_address), 32'd1);
      chk("w1_ready_low", 32'(data_ready), 32'd0);
      // confirm cycle, REQ, WAIT, then data_ready
      wait_ready(n);
      chk("turnaround", 32'(n), 32'd2);

      // five waitstates on the read of address 2
      ws_req = 5;
      pulse();
      pulse();
      a0 = accepts;
      for (int i = 0; i < 5; i++) begin
         chk("ws_read", 32'(fif.flash_mem_read), 32'd1);
         chk("ws_addr", 32'(fif.flash_mem_address), 32'd2);
         @(negedge clock50);
      end
      wait_ready(n);
      ws_req = 0;
      chk("ws_accepts", 32'(accepts - a0), 32'd1);
      chk("ws_data", 32'(getdata), 32'(exp16(16'h5555)));

      // direction change mid-word keeps the captured half order
      flash_word = 32'h12345678;
      key(8'h42);
      pulse();
      chk("dir_keep_order", 32'(getdata), 32'(exp16(16'hAAAA)));
      pulse();
      chk("back_addr1", 32'(fif.flash_mem_address), 32'd1);
      wait_ready(n);
      chk("back_half0", 32'(getdata), 32'(exp16(16'h1234)));
      pulse();
      chk("back_half1", 32'(getdata), 32'(exp16(16'h5678)));
      pulse();
      chk("back_addr0", 32'(fif.flash_mem_address), 32'd0);
      wait_ready(n);
      pulse();
      pulse();
      chk("back_wrap", 32'(fif.flash_mem_address), 32'h7FFFF);
      wait_ready(n);
      key(8'h46);
      pulse();
      pulse();
      chk("fwd_wrap", 32'(fif.flash_mem_address), 32'd0);

      // walk forward to address 100, then restart
      for (int i = 0; i < 100; i++) begin
         wait_ready(n);
         pulse();
         pulse();
      end
      chk("walk_addr100", 32'(fif.flash_mem_address), 32'd100);
      wait_ready(n);
      key(8'h52);
      pulse();
      pulse();
      chk("restart_fwd", 32'(fif.flash_mem_address), 32'd0);
      wait_ready(n);
      key(8'h42);
      pulse();
      key_control = 8'h52;
      pulse();
      key_control = 8'h00;
      chk("restart_back", 32'(fif.flash_mem_address), 32'h7FFFF);

      // confirm while waiting for data is ignored
      flash_word = 32'h0000BEEF;
      lat_req = 4;
      key(8'h46);
      pulse();
      chk("wait_ready_low", 32'(data_ready), 32'd0);
      wait_ready(n);
      chk("wait_half0", 32'(getdata), 32'(exp16(16'hBEEF)));
      pulse();
      chk("wait_half1", 32'(getdata), 32'(exp16(16'h0000)));
      chk("wait_ready_h1", 32'(data_ready), 32'd1);

      // reset in WAIT; the stale return lands while in REQ and must be dropped
      flash_word = 32'h11112222;
      lat_req = 3;
      pulse();
      @(negedge clock50);
      flash_word = 32'h33334444;
      rstn = 1'b0;
      #1;
      chk("mid_rst_read",  32'(fif.flash_mem_read), 32'd0);
      chk("mid_rst_ready", 32'(data_ready), 32'd0);
      chk("mid_rst_data",  32'(getdata), 32'd0);
      chk("mid_rst_addr",  32'(fif.flash_mem_address), 32'd0);
      @(negedge clock50);
      @(negedge clock50);
      lat_req = 0;
      rstn = 1'b1;
      wait_ready(n);
      chk("late_rdv_drop", 32'(getdata), 32'(exp16(16'h4444)));

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
